axi_rd_arbiter: RTL and testbench



---
 rtl/axi_rd_pkg.sv | 27 ++
 rtl/rd_req_picker.sv | 56 +++++
 rtl/axi_rd_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_pkg
// Shared definitions for the instruction-side AXI read arbiter:
//   - fixed AXI read-address encodings used by every transaction
//   - read FSM state encoding
//   - requester slot assignments on the req/gnt/done vectors
// No ports (package).
// -----------------------------------------------------------------------------
package axi_rd_pkg;

   // AXI encodings: 32-bit beats, incrementing bursts
   localparam logic [2:0] AXSIZE_WORD  = 3'b010;
   localparam logic [1:0] AXBURST_INCR = 2'b01;

   // Requester slots; lower index wins under fixed priority
   localparam int REQ_UNCACHED = 0;
   localparam int REQ_ICACHE   = 1;
   localparam int REQ_PREFETCH = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      DONE = 2'd3
   } rd_state_e;

endpackage

// File: rtl/rd_req_picker.sv
// -----------------------------------------------------------------------------
// rd_req_picker
// Combinational request picker. Scans the request vector starting at start_i
// (round-robin) or at index 0 (fixed priority) and returns the first asserted
// index.
//   req_i      in  NREQ   request levels
//   start_i    in  IDX_W  first index examined when RR != 0
//   gnt_idx_o  out IDX_W  winning requester index (0 when none)
//   gnt_vld_o  out 1      at least one request is asserted
// -----------------------------------------------------------------------------
module rd_req_picker #(
   parameter int NREQ  = 3,
   parameter int RR    = 0,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_vld_o
);

   // One spare bit so start + offset never overflows before the wrap
   localparam int CW = IDX_W + 1;

   logic [IDX_W-1:0] start_s;
   logic [CW-1:0]    cand_s;
   logic [IDX_W-1:0] idx_s;
   logic             found_s;

   assign start_s = (RR != 0) ? start_i : '0;

   // Walk the requesters once from start_s, wrapping modulo NREQ; first hit wins
   always_comb begin
      found_s = 1'b0;
      idx_s   = '0;
      cand_s  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand_s = {1'b0, start_s} + CW'(i);
         if (cand_s >= CW'(NREQ)) begin
            cand_s = cand_s - CW'(NREQ);
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req_i[cand_s[IDX_W-1:0]]) begin
            found_s = 1'b1;
            idx_s   = cand_s[IDX_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign gnt_idx_o = idx_s;
   assign gnt_vld_o = found_s;

endmodule

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Shares one AXI read channel (AR/R) between the instruction-side requesters
// (uncached fetch, icache refill, prefetcher). One transaction in flight; the
// R beats are collected into line_data and a one-cycle done pulse goes back
// to the owning requester.
//   clk, rst              clock, synchronous active-high reset
//   req/req_addr/req_burst per-requester request level, address, line flag
//   gnt                   one-hot, high in the AR handshake cycle
//   done                  one-hot, high for the single DONE cycle
//   line_data             assembled words, word k at [32k+31:32k]
//   rd_err                bad rresp or rid seen during the transaction
//   busy                  FSM not idle
//   ar* / r*              AXI read address and read data channels
// -----------------------------------------------------------------------------
module axi_rd_arbiter
   import axi_rd_pkg::*;
#(
   parameter int NREQ       = 3,
   parameter int LINE_WORDS = 8,
   parameter int ID_W       = 4,
   parameter int RR         = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*32-1:0]       req_addr,
   input  logic [NREQ-1:0]          req_burst,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic [LINE_WORDS*32-1:0] line_data,
   output logic                     rd_err,
   output logic                     busy,
   output logic [ID_W-1:0]          arid,
   output logic [31:0]              araddr,
   output logic [3:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic [1:0]               arlock,
   output logic [3:0]               arcache,
   output logic [2:0]               arprot,
   output logic                     arvalid,
   input  logic                     arready,
   input  logic [ID_W-1:0]          rid,
   input  logic [31:0]              rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready
);

   localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int OFF_W  = BEAT_W + 2;
   // Line reads start on a line boundary, single reads on a word boundary
   localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   rd_state_e                 state_q;
   logic [IDX_W-1:0]          win_q;
   logic                      burst_q;
   logic                      arvalid_q;
   logic                      rready_q;
   logic                      busy_q;
   logic [NREQ-1:0]           done_q;
   logic                      err_q;
   logic [31:0]               araddr_q;
   logic [3:0]                arlen_q;
   logic [ID_W-1:0]           arid_q;
   logic [BEAT_W-1:0]         beat_cnt_q;
   logic [LINE_WORDS*32-1:0]  line_q;
   logic [IDX_W-1:0]          rr_ptr_q;

   logic [IDX_W-1:0]          pick_idx_s;
   logic                      pick_vld_s;
   logic [31:0]               sel_addr_s;
   logic                      sel_burst_s;
   logic [31:0]               araddr_d;
   logic [3:0]                arlen_d;
   logic [IDX_W-1:0]          rr_ptr_d;
   logic [NREQ-1:0]           win_oh_s;
   logic [BEAT_W-1:0]         wr_idx_s;
   logic                      beat_acc_s;
   logic                      id_ok_s;

   rd_req_picker #(
      .NREQ  (NREQ),
      .RR    (RR),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i     (req),
      .start_i   (rr_ptr_q),
      .gnt_idx_o (pick_idx_s),
      .gnt_vld_o (pick_vld_s)
   );

   // AR fields for the current picker winner, latched on IDLE -> AR
   always_comb begin
      sel_addr_s  = req_addr[{pick_idx_s, 5'b00000} +: 32];
      sel_burst_s = req_burst[pick_idx_s];
      if (sel_burst_s) begin
         araddr_d = sel_addr_s & LINE_MASK;
         arlen_d  = 4'(LINE_WORDS - 1);
      end else begin
         araddr_d = sel_addr_s & WORD_MASK;
         arlen_d  = 4'd0;
      end
   end

   // Round-robin pointer resumes one past the owner, wrapping at NREQ
   always_comb begin
      if (win_q == IDX_W'(NREQ - 1)) begin
         rr_ptr_d = '0;
      end else begin
         rr_ptr_d = win_q + IDX_W'(1);
      end
   end

   // Owner one-hot, beat acceptance and write slot for the line buffer
   always_comb begin
      win_oh_s        = '0;
      win_oh_s[win_q] = 1'b1;
      beat_acc_s      = (state_q == R) && rvalid && rready_q;
      id_ok_s         = (rid == arid_q);
      if (burst_q) begin
         wr_idx_s = beat_cnt_q;
      end else begin
         wr_idx_s = '0;
      end
   end

   // Read FSM with all AR/R outputs and the line buffer registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         win_q      <= '0;
         burst_q    <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= '0;
         err_q      <= 1'b0;
         araddr_q   <= 32'd0;
         arlen_q    <= 4'd0;
         arid_q     <= '0;
         beat_cnt_q <= '0;
         line_q     <= '0;
         rr_ptr_q   <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (pick_vld_s) begin
                  state_q    <= AR;
                  win_q      <= pick_idx_s;
                  burst_q    <= sel_burst_s;
                  araddr_q   <= araddr_d;
                  arlen_q    <= arlen_d;
                  arid_q     <= ID_W'(pick_idx_s);
                  arvalid_q  <= 1'b1;
                  busy_q     <= 1'b1;
                  beat_cnt_q <= '0;
                  err_q      <= 1'b0;
               end
            end
            AR: begin
               if (arready) begin
                  state_q   <= R;
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  rr_ptr_q  <= rr_ptr_d;
               end
            end
            R: begin
               if (beat_acc_s) begin
                  beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                  // A beat with the wrong rid is consumed but never stored
                  if (id_ok_s) begin
                     line_q[{wr_idx_s, 5'b00000} +: 32] <= rdata;
                  end
                  if ((rresp != 2'b00) || !id_ok_s) begin
                     err_q <= 1'b1;
                  end
                  if (rlast) begin
                     state_q  <= DONE;
                     rready_q <= 1'b0;
                     done_q   <= win_oh_s;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               arvalid_q <= 1'b0;
               rready_q  <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = (arvalid_q && arready) ? win_oh_s : '0;
   assign done      = done_q;
   assign line_data = line_q;
   assign rd_err    = err_q;
   assign busy      = busy_q;
   assign arid      = arid_q;
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arsize    = AXSIZE_WORD;
   assign arburst   = AXBURST_INCR;
   assign arlock    = 2'b00;
   assign arcache   = 4'b0000;
   assign arprot    = 3'b000;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Two arbiter instances: index 0 fixed priority, index 1 round-robin. A small
// AXI slave task answers each read; expected owner/address/line/error are
// pushed to a scoreboard before the request and popped at done.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

   localparam int NREQ = 3;
   localparam int LW   = 8;
   localparam int ID_W = 4;

   typedef struct {
      logic [NREQ-1:0]  owner;
      logic [31:0]      araddr;
      logic [3:0]       arlen;
      logic [LW*32-1:0] line;
      logic             err;
   } exp_t;

   logic clk;
   logic             rst_v     [2];
   logic [NREQ-1:0]  req_v     [2];
   logic [NREQ*32-1:0] addr_v  [2];
   logic [NREQ-1:0]  burst_v   [2];
   logic             arready_v [2];
   logic [ID_W-1:0]  rid_v     [2];
   logic [31:0]      rdata_v   [2];
   logic [1:0]       rresp_v   [2];
   logic             rlast_v   [2];
   logic             rvalid_v  [2];
   wire  [NREQ-1:0]  gnt_v     [2];
   wire  [NREQ-1:0]  done_v    [2];
   wire  [LW*32-1:0] line_v    [2];
   wire              rd_err_v  [2];
   wire              busy_v    [2];
   wire  [ID_W-1:0]  arid_v    [2];
   wire  [31:0]      araddr_v  [2];
   wire  [3:0]       arlen_v   [2];
   wire  [2:0]       arsize_v  [2];
   wire  [1:0]       arburst_v [2];
   wire  [1:0]       arlock_v  [2];
   wire  [3:0]       arcache_v [2];
   wire  [2:0]       arprot_v  [2];
   wire              arvalid_v [2];
   wire              rready_v  [2];

   exp_t             sb_q[$];
   logic [LW*32-1:0] shadow [2];
   int               n_chk;
   int               n_fail;

   axi_rd_arbiter #(.NREQ(NREQ), .LINE_WORDS(LW), .ID_W(ID_W), .RR(0)) u_fp (
      .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .req_addr(addr_v[0]), .req_burst(burst_v[0]),
      .gnt(gnt_v[0]), .done(done_v[0]), .line_data(line_v[0]), .rd_err(rd_err_v[0]), .busy(busy_v[0]),
      .arid(arid_v[0]), .araddr(araddr_v[0]), .arlen(arlen_v[0]), .arsize(arsize_v[0]),
      .arburst(arburst_v[0]), .arlock(arlock_v[0]), .arcache(arcache_v[0]), .arprot(arprot_v[0]),
      .arvalid(arvalid_v[0]), .arready(arready_v[0]), .rid(rid_v[0]), .rdata(rdata_v[0]),
      .rresp(rresp_v[0]), .rlast(rlast_v[0]), .rvalid(rvalid_v[0]), .rready(rready_v[0])
   );

   axi_rd_arbiter #(.NREQ(NREQ), .LINE_WORDS(LW), .ID_W(ID_W), .RR(1)) u_rr (
      .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .req_addr(addr_v[1]), .req_burst(burst_v[1]),
      .gnt(gnt_v[1]), .done(done_v[1]), .line_data(line_v[1]), .rd_err(rd_err_v[1]), .busy(busy_v[1]),
      .arid(arid_v[1]), .araddr(araddr_v[1]), .arlen(arlen_v[1]), .arsize(arsize_v[1]),
      .arburst(arburst_v[1]), .arlock(arlock_v[1]), .arcache(arcache_v[1]), .arprot(arprot_v[1]),
      .arvalid(arvalid_v[1]), .arready(arready_v[1]), .rid(rid_v[1]), .rdata(rdata_v[1]),
      .rresp(rresp_v[1]), .rlast(rlast_v[1]), .rvalid(rvalid_v[1]), .rready(rready_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected line after a read: previous contents with the accepted beats applied
   function automatic logic [LW*32-1:0] model_line(input int d, input logic burst, input int nbeats,
                                                   input int badid, input logic [31:0] base);
      logic [LW*32-1:0] l;
      int w;
      l = shadow[d];
      for (int b = 0; b < nbeats; b++) begin
         w = burst ? (b % LW) : 0;
         if (b != badid) l[32*w +: 32] = base + 32'(b);
      end
      shadow[d] = l;
      return l;
   endfunction

   // AXI slave: waits for arvalid, holds arready off ar_dly cycles, then returns
   // nbeats beats (data base+b). Leaves the caller at the DONE-cycle negedge.
   task automatic serve(input int d, input int nbeats, input int ar_dly, input int gap,
                        input int err_beat, input int badid_beat, input int abort_after,
                        input logic [NREQ-1:0] drop_mask, input logic [31:0] base,
                        output logic ok, output int lat, output logic [NREQ-1:0] g,
                        output logic [31:0] a, output logic [3:0] len, output logic [ID_W-1:0] id);
      ok = 1'b1; lat = 0; g = '0; a = '0; len = '0; id = '0;
      while (arvalid_v[d] !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (arvalid_v[d] !== 1'b1) begin
         ok = 1'b0;
         return;
      end
      a = araddr_v[d];
      for (int k = 0; k < ar_dly; k++) begin
         @(negedge clk);
         if (arvalid_v[d] !== 1'b1 || araddr_v[d] !== a || gnt_v[d] !== 3'b000) ok = 1'b0;
      end
      arready_v[d] = 1'b1;
      #1;
      g = gnt_v[d]; a = araddr_v[d]; len = arlen_v[d]; id = arid_v[d];
      @(negedge clk);
      arready_v[d] = 1'b0;
      req_v[d] = req_v[d] & ~drop_mask;
      for (int b = 0; b < nbeats; b++) begin
         if (b == abort_after) begin
            rvalid_v[d] = 1'b1; rdata_v[d] = base + 32'(b); rresp_v[d] = 2'b00;
            rid_v[d] = id; rlast_v[d] = 1'b0;
            return;
         end
         for (int k = 0; k < gap; k++) begin
            rvalid_v[d] = 1'b0;
            @(negedge clk);
            if (done_v[d] !== 3'b000) ok = 1'b0;
         end
         rvalid_v[d] = 1'b1;
         rdata_v[d]  = base + 32'(b);
         rresp_v[d]  = (b == err_beat) ? 2'b10 : 2'b00;
         rid_v[d]    = (b == badid_beat) ? 4'd5 : id;
         rlast_v[d]  = (b == nbeats - 1);
         if (rready_v[d] !== 1'b1 || done_v[d] !== 3'b000) ok = 1'b0;
         @(negedge clk);
      end
      rvalid_v[d] = 1'b0; rlast_v[d] = 1'b0; rresp_v[d] = 2'b00;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b1; req_v[d] = '0; addr_v[d] = '0; burst_v[d] = '0; arready_v[d] = 1'b0;
         rid_v[d] = '0; rdata_v[d] = '0; rresp_v[d] = 2'b00; rlast_v[d] = 1'b0; rvalid_v[d] = 1'b0;
         shadow[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_chk++; if (arvalid_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid[%0d]: got %b want 0", d, arvalid_v[d]); end
         n_chk++; if (rready_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rready[%0d]: got %b want 0", d, rready_v[d]); end
         n_chk++; if (gnt_v[d] !== 3'b000) begin n_fail++; $display("FAIL reset_gnt[%0d]: got %b want 000", d, gnt_v[d]); end
         n_chk++; if (done_v[d] !== 3'b000) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 000", d, done_v[d]); end
         n_chk++; if (rd_err_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err[%0d]: got %b want 0", d, rd_err_v[d]); end
         n_chk++; if (busy_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy_v[d]); end
         n_chk++; if (line_v[d] !== '0) begin n_fail++; $display("FAIL reset_line[%0d]: got %h want 0", d, line_v[d]); end
         n_chk++; if (araddr_v[d] !== 32'd0 || arid_v[d] !== 4'd0) begin n_fail++; $display("FAIL reset_ar[%0d]: got %h/%h want 0/0", d, araddr_v[d], arid_v[d]); end
      end
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      exp_t e; logic ok; int lat; logic [NREQ-1:0] g; logic [31:0] a; logic [3:0] len; logic [ID_W-1:0] id;
      addr_v[0] = {32'h0, 32'h0, 32'h1FC0_0004}; burst_v[0] = 3'b000;
      e.owner = 3'b001; e.araddr = 32'h1FC0_0004; e.arlen = 4'd0; e.err = 1'b0;
      e.line = model_line(0, 1'b0, 1, -1, 32'hDEAD_BEEF);
      sb_q.push_back(e);
      req_v[0] = 3'b001;
      serve(0, 1, 2, 0, -1, -1, -1, 3'b000, 32'hDEAD_BEEF, ok, lat, g, a, len, id);
      req_v[0] = 3'b000;
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_handshake: ok=%b want 1", ok); end
      n_chk++; if (lat != 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", lat); end
      n_chk++; if (g !== sb_q[0].owner) begin n_fail++; $display("FAIL single_gnt: got %b want %b", g, sb_q[0].owner); end
      n_chk++; if (a !== sb_q[0].araddr || len !== sb_q[0].arlen || id !== 4'd0) begin n_fail++; $display("FAIL single_ar: got %h/%0d/%0d want %h/%0d/0", a, len, id, sb_q[0].araddr, sb_q[0].arlen); end
      n_chk++; if (arsize_v[0] !== 3'b010 || arlock_v[0] !== 2'b00 || arcache_v[0] !== 4'd0 || arprot_v[0] !== 3'd0) begin n_fail++; $display("FAIL single_fixed_ar: got %b/%b/%b/%b", arsize_v[0], arlock_v[0], arcache_v[0], arprot_v[0]); end
      e = sb_q.pop_front();
      n_chk++; if (done_v[0] !== e.owner) begin n_fail++; $display("FAIL single_done: got %b want %b", done_v[0], e.owner); end
      n_chk++; if (line_v[0] !== e.line) begin n_fail++; $display("FAIL single_line: got %h want %h", line_v[0], e.line); end
      n_chk++; if (rd_err_v[0] !== e.err) begin n_fail++; $display("FAIL single_err: got %b want %b", rd_err_v[0], e.err); end
      @(negedge clk);
      n_chk++; if (done_v[0] !== 3'b000 || busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL single_after: done %b busy %b want 000 0", done_v[0], busy_v[0]); end
      n_chk++; if (line_v[0] !== e.line) begin n_fail++; $display("FAIL single_line_hold: got %h want %h", line_v[0], e.line); end
   endtask

   task automatic test_burst();
      exp_t e; logic ok; int lat; logic [NREQ-1:0] g; logic [31:0] a; logic [3:0] len; logic [ID_W-1:0] id;
      addr_v[0] = {32'h0, 32'h0000_1234, 32'h0}; burst_v[0] = 3'b010;
      e.owner = 3'b010; e.araddr = 32'h0000_1220; e.arlen = 4'd7; e.err = 1'b0;
      e.line = model_line(0, 1'b1, 8, -1, 32'd0);
      sb_q.push_back(e);
      req_v[0] = 3'b010;
      serve(0, 8, 0, 1, -1, -1, -1, 3'b000, 32'd0, ok, lat, g, a, len, id);
      req_v[0] = 3'b000;
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL burst_handshake: ok=%b want 1 (includes early done)", ok); end
      n_chk++; if (g !== sb_q[0].owner || id !== 4'd1) begin n_fail++; $display("FAIL burst_gnt: got %b id %0d want %b id 1", g, id, sb_q[0].owner); end
      n_chk++; if (a !== sb_q[0].araddr || len !== sb_q[0].arlen) begin n_fail++; $display("FAIL burst_ar: got %h/%0d want %h/%0d", a, len, sb_q[0].araddr, sb_q[0].arlen); end
      n_chk++; if (arburst_v[0] !== 2'b01) begin n_fail++; $display("FAIL burst_arburst: got %b want 01", arburst_v[0]); end
      e = sb_q.pop_front();
      n_chk++; if (done_v[0] !== e.owner) begin n_fail++; $display("FAIL burst_done: got %b want %b", done_v[0], e.owner); end
      n_chk++; if (line_v[0] !== e.line) begin n_fail++; $display("FAIL burst_line: got %h want %h", line_v[0], e.line); end
      n_chk++; if (rd_err_v[0] !== e.err) begin n_fail++; $display("FAIL burst_err: got %b want %b", rd_err_v[0], e.err); end
      @(negedge clk);
   endtask

   // ord holds four 2-bit expected winner indices, first at [1:0]
   task automatic test_contention(input int d, input logic [7:0] ord);
      exp_t e; logic ok; int lat; logic [NREQ-1:0] g; logic [31:0] a; logic [3:0] len; logic [ID_W-1:0] id;
      int r;
      addr_v[d] = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100}; burst_v[d] = 3'b000;
      req_v[d] = 3'b111;
      for (int i = 0; i < 4; i++) begin
         r = int'(ord[2*i +: 2]);
         e.owner = 3'b001 << r; e.araddr = 32'h100 * 32'(r + 1); e.arlen = 4'd0; e.err = 1'b0;
         e.line = model_line(d, 1'b0, 1, -1, 32'hC000 + 32'(i));
         sb_q.push_back(e);
         serve(d, 1, 0, 0, -1, -1, -1, 3'b000, 32'hC000 + 32'(i), ok, lat, g, a, len, id);
         n_chk++; if (ok !== 1'b1 || g !== sb_q[0].owner) begin n_fail++; $display("FAIL contention%0d_gnt%0d: got %b ok %b want %b", d, i, g, ok, sb_q[0].owner); end
         n_chk++; if (a !== sb_q[0].araddr || id !== 4'(r)) begin n_fail++; $display("FAIL contention%0d_ar%0d: got %h/%0d want %h/%0d", d, i, a, id, sb_q[0].araddr, r); end
         e = sb_q.pop_front();
         n_chk++; if (done_v[d] !== e.owner || line_v[d] !== e.line) begin n_fail++; $display("FAIL contention%0d_done%0d: got %b %h want %b %h", d, i, done_v[d], line_v[d][31:0], e.owner, e.line[31:0]); end
      end
      req_v[d] = 3'b000;
      @(negedge clk);
   endtask

   task automatic test_error();
      exp_t e; logic ok; int lat; logic [NREQ-1:0] g; logic [31:0] a; logic [3:0] len; logic [ID_W-1:0] id;
      addr_v[0] = {32'h0000_0044, 32'h0, 32'h0000_0010}; burst_v[0] = 3'b100;
      for (int t = 0; t < 2; t++) begin
         if (t == 0) begin
            e.owner = 3'b100; e.araddr = 32'h40; e.arlen = 4'd7; e.err = 1'b1;
            e.line = model_line(0, 1'b1, 8, 5, 32'h500);
            req_v[0] = 3'b100;
         end else begin
            e.owner = 3'b001; e.araddr = 32'h10; e.arlen = 4'd0; e.err = 1'b0;
            e.line = model_line(0, 1'b0, 1, -1, 32'h600);
            req_v[0] = 3'b001;
         end
         sb_q.push_back(e);
         if (t == 0) serve(0, 8, 1, 0, 3, 5, -1, 3'b000, 32'h500, ok, lat, g, a, len, id);
         else        serve(0, 1, 0, 0, -1, -1, -1, 3'b000, 32'h600, ok, lat, g, a, len, id);
         req_v[0] = 3'b000;
         n_chk++; if (ok !== 1'b1 || g !== sb_q[0].owner || a !== sb_q[0].araddr) begin n_fail++; $display("FAIL error%0d_ar: got %b %h ok %b want %b %h", t, g, a, ok, sb_q[0].owner, sb_q[0].araddr); end
         e = sb_q.pop_front();
         n_chk++; if (done_v[0] !== e.owner) begin n_fail++; $display("FAIL error%0d_done: got %b want %b", t, done_v[0], e.owner); end
         n_chk++; if (rd_err_v[0] !== e.err) begin n_fail++; $display("FAIL error%0d_rd_err: got %b want %b", t, rd_err_v[0], e.err); end
         n_chk++; if (line_v[0] !== e.line) begin n_fail++; $display("FAIL error%0d_line: got %h want %h", t, line_v[0], e.line); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e; logic ok; int lat; logic [NREQ-1:0] g; logic [31:0] a; logic [3:0] len; logic [ID_W-1:0] id;
      addr_v[0] = {32'h0, 32'h0000_0080, 32'h0}; burst_v[0] = 3'b010;
      req_v[0] = 3'b010;
      serve(0, 8, 0, 0, -1, -1, 3, 3'b000, 32'h700, ok, lat, g, a, len, id);
      n_chk++; if (ok !== 1'b1 || g !== 3'b010) begin n_fail++; $display("FAIL rstmid_gnt: got %b ok %b want 010", g, ok); end
      rst_v[0] = 1'b1; req_v[0] = 3'b000;
      @(negedge clk);
      n_chk++; if (busy_v[0] !== 1'b0 || rready_v[0] !== 1'b0 || arvalid_v[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: busy %b rready %b arvalid %b want 0 0 0", busy_v[0], rready_v[0], arvalid_v[0]); end
      n_chk++; if (line_v[0] !== '0) begin n_fail++; $display("FAIL rstmid_line: got %h want 0", line_v[0]); end
      rst_v[0] = 1'b0;
      shadow[0] = '0;
      @(negedge clk);
      n_chk++; if (rready_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: rready %b busy %b want 0 0", rready_v[0], busy_v[0]); end
      rvalid_v[0] = 1'b0;
      e.owner = 3'b010; e.araddr = 32'h80; e.arlen = 4'd7; e.err = 1'b0;
      e.line = model_line(0, 1'b1, 8, -1, 32'h900);
      sb_q.push_back(e);
      req_v[0] = 3'b010;
      serve(0, 8, 0, 0, -1, -1, -1, 3'b000, 32'h900, ok, lat, g, a, len, id);
      req_v[0] = 3'b000;
      n_chk++; if (ok !== 1'b1 || a !== sb_q[0].araddr) begin n_fail++; $display("FAIL rstmid_fresh_ar: got %h ok %b want %h", a, ok, sb_q[0].araddr); end
      e = sb_q.pop_front();
      n_chk++; if (done_v[0] !== e.owner || line_v[0] !== e.line) begin n_fail++; $display("FAIL rstmid_fresh_line: got %b %h want %b %h", done_v[0], line_v[0], e.owner, e.line); end
      @(negedge clk);
   endtask

   task automatic test_drop();
      exp_t e; logic ok; int lat; logic [NREQ-1:0] g; logic [31:0] a; logic [3:0] len; logic [ID_W-1:0] id;
      addr_v[0] = {32'h0, 32'h0000_2010, 32'h0000_1000}; burst_v[0] = 3'b010;
      e.owner = 3'b001; e.araddr = 32'h1000; e.arlen = 4'd0; e.err = 1'b0;
      e.line = model_line(0, 1'b0, 1, -1, 32'hA00);
      sb_q.push_back(e);
      e.owner = 3'b010; e.araddr = 32'h2000; e.arlen = 4'd7; e.err = 1'b0;
      e.line = model_line(0, 1'b1, 8, -1, 32'hB00);
      sb_q.push_back(e);
      req_v[0] = 3'b011;
      for (int t = 0; t < 2; t++) begin
         if (t == 0) serve(0, 1, 0, 2, -1, -1, -1, 3'b001, 32'hA00, ok, lat, g, a, len, id);
         else        serve(0, 8, 0, 0, -1, -1, -1, 3'b000, 32'hB00, ok, lat, g, a, len, id);
         if (t == 1) req_v[0] = 3'b000;
         n_chk++; if (ok !== 1'b1 || g !== sb_q[0].owner || a !== sb_q[0].araddr) begin n_fail++; $display("FAIL drop%0d_ar: got %b %h ok %b want %b %h", t, g, a, ok, sb_q[0].owner, sb_q[0].araddr); end
         e = sb_q.pop_front();
         n_chk++; if (done_v[0] !== e.owner || arvalid_v[0] !== 1'b0) begin n_fail++; $display("FAIL drop%0d_done: done %b arvalid %b want %b 0", t, done_v[0], arvalid_v[0], e.owner); end
         n_chk++; if (line_v[0] !== e.line) begin n_fail++; $display("FAIL drop%0d_line: got %h want %h", t, line_v[0], e.line); end
      end
      @(negedge clk);
      n_chk++; if (busy_v[0] !== 1'b0 || sb_q.size() != 0) begin n_fail++; $display("FAIL drop_end: busy %b queue %0d want 0 0", busy_v[0], sb_q.size()); end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_single();
      test_burst();
      test_contention(0, 8'b00_00_00_00);
      test_contention(1, 8'b00_10_01_00);
      test_error();
      test_reset_mid();
      test_drop();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
